// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// synth_pkg : shared note table, key offsets and voice record for the synth
//             keypad front end.
// Rev 1.0
// ============================================================================
package synth_pkg;

  localparam int NOTE_TABLE_LEN = 13;
  localparam int NOTE_DIV_W     = 18;
  localparam int IDX_W          = 8;

  // Octave-0 clock dividers for a 10 MHz clock, C2 upward in semitones.
  localparam logic [NOTE_DIV_W-1:0] NOTE_BASE_DIV [NOTE_TABLE_LEN] = '{
    18'd152889, 18'd144309, 18'd136210, 18'd128565, 18'd121349, 18'd114538,
    18'd108110, 18'd102042, 18'd96315,  18'd90909,  18'd85807,  18'd80991,
    18'd76445
  };

  // Control keys sit just above the note keys.
  localparam int KEY_OCT_UP = 0;
  localparam int KEY_OCT_DN = 1;
  localparam int KEY_MODE   = 2;

  typedef struct packed {
    logic             active;
    logic [IDX_W-1:0] key;
    logic [IDX_W-1:0] rank;
  } voice_t;

  function automatic logic [NOTE_DIV_W-1:0] note_base_div(input logic [IDX_W-1:0] k);
    note_base_div = '0;
    for (int i = 0; i < NOTE_TABLE_LEN; i++) begin
      if (k == IDX_W'(i)) note_base_div = NOTE_BASE_DIV[i];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : two-flop synchroniser plus counter debounce for one key,
//                with registered one-cycle rise/fall pulses.
// Rev 1.0
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
        cnt  <= '0;
        deb  <= sync2;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/poly_input_driver.sv
`default_nettype none
// ============================================================================
// poly_input_driver : polyphonic keypad front end - debounce, oldest-voice
//                     stealing allocation, octave/mode control, divider words.
// Rev 1.0
// ============================================================================
module poly_input_driver
  import synth_pkg::*;
#(
  parameter  int NKEYS    = 13,
  parameter  int NVOICES  = 4,
  parameter  int DIV_W    = 18,
  parameter  int OCT_MAX  = 4,
  parameter  int NMODES   = 4,
  parameter  int DEBOUNCE = 2500,
  localparam int MODE_W   = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NKEYS+2:0]         keypad,
  output logic [NVOICES*DIV_W-1:0] divider,
  output logic [NVOICES-1:0]       active,
  output logic [MODE_W-1:0]        mode,
  output logic [NVOICES-1:0]       strobe
);

  localparam int OCT_W = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1;

  logic [NKEYS+2:0]         deb, rise, fall;
  logic [NKEYS-1:0]         served, served_n;
  voice_t                   voice_q [NVOICES];
  voice_t                   voice_n [NVOICES];
  logic [OCT_W-1:0]         octave, octave_n;
  logic [MODE_W-1:0]        mode_n;
  logic [NVOICES*DIV_W-1:0] divider_n;
  logic [NVOICES-1:0]       active_n, strobe_n, released, tgt;
  logic                     press_found, free_found, oct_up, oct_dn;
  logic [IDX_W-1:0]         press_key, tgt_rank;
  logic                     unused_edges;

  for (genvar i = 0; i < NKEYS + 3; i++) begin : g_key
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (keypad[i]),
      .deb  (deb[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign unused_edges = ^{fall, rise[NKEYS-1:0], deb[NKEYS+2:NKEYS]};

  // Releases all land this cycle; at most one new press is served per cycle.
  always_comb begin
    served_n    = served;
    released    = '0;
    press_found = 1'b0;
    press_key   = '0;
    free_found  = 1'b0;
    tgt         = '0;
    tgt_rank    = '0;
    for (int v = 0; v < NVOICES; v++) voice_n[v] = voice_q[v];

    for (int k = 0; k < NKEYS; k++) begin
      if (served[k] && !deb[k]) begin
        served_n[k] = 1'b0;
        for (int v = 0; v < NVOICES; v++) begin
          if (voice_q[v].active && voice_q[v].key == IDX_W'(k)) begin
            voice_n[v].active = 1'b0;
            released[v]       = 1'b1;
          end
        end
      end else if (!press_found && deb[k] && !served[k]) begin
        press_found = 1'b1;
        press_key   = IDX_W'(k);
        served_n[k] = 1'b1;
      end
    end

    for (int v = 0; v < NVOICES; v++) begin
      if (!free_found && !voice_n[v].active && !released[v]) begin
        free_found = 1'b1;
        tgt[v]     = 1'b1;
      end
    end
    if (!free_found) begin
      for (int v = 0; v < NVOICES; v++) tgt[v] = (voice_q[v].rank == IDX_W'(NVOICES - 1));
    end
    for (int v = 0; v < NVOICES; v++) begin
      if (tgt[v]) tgt_rank = voice_q[v].rank;
    end

    if (press_found) begin
      for (int v = 0; v < NVOICES; v++) begin
        if (tgt[v]) begin
          voice_n[v].active = 1'b1;
          voice_n[v].key    = press_key;
          voice_n[v].rank   = '0;
        end else if (voice_q[v].rank < tgt_rank) begin
          voice_n[v].rank = voice_q[v].rank + IDX_W'(1);
        end
      end
    end
  end

  // Dividers use next-state octave so an octave step and its re-tune share an edge.
  always_comb begin
    oct_up   = rise[NKEYS+KEY_OCT_UP];
    oct_dn   = rise[NKEYS+KEY_OCT_DN];
    octave_n = octave;
    if (oct_up && !oct_dn && octave != OCT_W'(OCT_MAX)) octave_n = octave + OCT_W'(1);
    else if (oct_dn && !oct_up && octave != '0)         octave_n = octave - OCT_W'(1);

    mode_n = mode;
    if (rise[NKEYS+KEY_MODE]) mode_n = (mode == MODE_W'(NMODES - 1)) ? '0 : mode + MODE_W'(1);

    divider_n = '0;
    active_n  = '0;
    strobe_n  = '0;
    for (int v = 0; v < NVOICES; v++) begin
      active_n[v] = voice_n[v].active;
      if (voice_n[v].active)
        divider_n[v*DIV_W +: DIV_W] = DIV_W'(note_base_div(voice_n[v].key)) >> octave_n;
      strobe_n[v] = {active_n[v], divider_n[v*DIV_W +: DIV_W]} !=
                    {active[v],   divider[v*DIV_W +: DIV_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      served  <= '0;
      octave  <= '0;
      mode    <= '0;
      divider <= '0;
      active  <= '0;
      strobe  <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        voice_q[v].active <= 1'b0;
        voice_q[v].key    <= '0;
        voice_q[v].rank   <= IDX_W'(v);
      end
    end else begin
      served  <= served_n;
      octave  <= octave_n;
      mode    <= mode_n;
      divider <= divider_n;
      active  <= active_n;
      strobe  <= strobe_n;
      for (int v = 0; v < NVOICES; v++) voice_q[v] <= voice_n[v];
    end
  end

endmodule
`default_nettype wire
